// File: rtl/fft_loop_sequencer.sv
// -----------------------------------------------------------------------------
// fft_loop_sequencer
//
// Drives the radix-2 FFT butterfly loop nest. For every butterfly it presents
// the stage half-length m, the index i within the group, the group index k and
// the two operand addresses. i is the innermost loop, then k, then m.
// Forward transforms step m = 1, 2, ..., N/2. Inverse transforms step
// m = N/2, ..., 2, 1.
//
// Optional feature: define FFT_SEQ_STALL_EN to make the stall input freeze the
// butterfly tuple during RUN. Without the macro the stall port is present but
// has no effect.
//
// Ports:
//   clk             clock
//   rst             synchronous, active-high reset
//   start           one-cycle launch pulse, accepted only when idle
//   is_forward_fft  transform direction, latched on the accepted start
//   stall           datapath back-pressure (only with FFT_SEQ_STALL_EN)
//   busy            high from the cycle after an accepted start until done
//   valid           m, i, k, addr_top and addr_bot describe a butterfly
//   m, i, k         loop indices (LOG_N bits each)
//   addr_top        k*2m + i
//   addr_bot        addr_top + m
//   i_loop_done     high with valid on the last butterfly of a stage
//   tw_rst          one-cycle reset for the twiddle storage base pointer
//   done            one-cycle pulse after the final butterfly
// -----------------------------------------------------------------------------
module fft_loop_sequencer #(
    parameter int LOG_N = 13
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             is_forward_fft,
    input  logic             stall,
    output logic             busy,
    output logic             valid,
    output logic [LOG_N-1:0] m,
    output logic [LOG_N-1:0] i,
    output logic [LOG_N-1:0] k,
    output logic [LOG_N-1:0] addr_top,
    output logic [LOG_N-1:0] addr_bot,
    output logic             i_loop_done,
    output logic             tw_rst,
    output logic             done
);

    // Width of log2(m); must hold values up to LOG_N (the shift for 2m).
    localparam int               LGW     = $clog2(LOG_N + 1);
    localparam logic [LGW-1:0]   LG_LAST = LGW'(LOG_N - 1);
    localparam logic [LOG_N-1:0] M_HALF  = {1'b1, {(LOG_N-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE,
        S_INIT,
        S_RUN,
        S_DONE
    } state_t;

    state_t           r_state, w_state_nxt;
    logic             r_fwd, w_fwd_nxt;
    logic [LOG_N-1:0] r_m, w_m_nxt;
    logic [LOG_N-1:0] r_i, w_i_nxt;
    logic [LOG_N-1:0] r_k, w_k_nxt;
    logic [LGW-1:0]   r_lg, w_lg_nxt;     // log2(r_m), kept so addresses are pure shifts

    logic [LGW-1:0]   w_shamt;
    logic [LOG_N-1:0] w_addr_top;
    logic [LOG_N-1:0] w_addr_bot;
    logic             w_last_i;
    logic             w_stage_end;
    logic             w_final_stage;
    logic             w_advance;

`ifdef FFT_SEQ_STALL_EN
    assign w_advance = ~stall;
`else
    assign w_advance = 1'b1;
    // Port kept for integration; intentionally has no effect in this build.
    logic w_unused_stall;
    assign w_unused_stall = stall;
`endif

    // k occupies the bits above log2(2m) and i the bits below log2(m), so the
    // sum k*2m + i is an OR, and adding m just sets the (always clear) m bit.
    assign w_shamt    = r_lg + LGW'(1);
    assign w_addr_top = (r_k << w_shamt) | r_i;
    assign w_addr_bot = w_addr_top | r_m;

    assign w_last_i      = (r_i == r_m - LOG_N'(1));
    // addr_bot is all ones exactly when i == m-1 and k == N/(2m)-1.
    assign w_stage_end   = (w_addr_bot == '1);
    assign w_final_stage = r_fwd ? (r_lg == LG_LAST) : (r_lg == '0);

    // NOTE: every combinational output is given a default before the case so
    // no path leaves a signal unassigned, which would infer a latch.
    always_comb begin
        w_state_nxt = r_state;
        w_fwd_nxt   = r_fwd;
        w_m_nxt     = r_m;
        w_i_nxt     = r_i;
        w_k_nxt     = r_k;
        w_lg_nxt    = r_lg;

        unique case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_fwd_nxt   = is_forward_fft;
                    w_state_nxt = S_INIT;
                end
            end

            S_INIT: begin
                w_i_nxt     = '0;
                w_k_nxt     = '0;
                w_m_nxt     = r_fwd ? LOG_N'(1) : M_HALF;
                w_lg_nxt    = r_fwd ? '0 : LG_LAST;
                w_state_nxt = S_RUN;
            end

            S_RUN: begin
                if (w_advance) begin
                    if (!w_last_i) begin
                        w_i_nxt = r_i + LOG_N'(1);
                    end else begin
                        w_i_nxt = '0;
                        if (!w_stage_end) begin
                            w_k_nxt = r_k + LOG_N'(1);
                        end else begin
                            w_k_nxt = '0;
                            if (w_final_stage) begin
                                w_state_nxt = S_DONE;
                            end else if (r_fwd) begin
                                w_m_nxt  = r_m << 1;
                                w_lg_nxt = r_lg + LGW'(1);
                            end else begin
                                w_m_nxt  = r_m >> 1;
                                w_lg_nxt = r_lg - LGW'(1);
                            end
                        end
                    end
                end
            end

            S_DONE: begin
                w_state_nxt = S_IDLE;
            end

            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_fwd   <= 1'b0;
            r_m     <= '0;
            r_i     <= '0;
            r_k     <= '0;
            r_lg    <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_fwd   <= w_fwd_nxt;
            r_m     <= w_m_nxt;
            r_i     <= w_i_nxt;
            r_k     <= w_k_nxt;
            r_lg    <= w_lg_nxt;
        end
    end

    assign busy        = (r_state != S_IDLE);
    assign valid       = (r_state == S_RUN);
    assign tw_rst      = (r_state == S_INIT);
    assign done        = (r_state == S_DONE);
    assign i_loop_done = valid && w_stage_end;
    assign m           = r_m;
    assign i           = r_i;
    assign k           = r_k;
    assign addr_top    = w_addr_top;
    assign addr_bot    = w_addr_bot;

endmodule

// File: tb/tb_fft_loop_sequencer.sv
// -----------------------------------------------------------------------------
// tb_fft_loop_sequencer
//
// Scoreboard bench for fft_loop_sequencer. A LOG_N=3 instance is driven with
// directed transforms; the expected butterfly tuples are hand-written tables
// pushed into a queue at launch and popped by a monitor on each accepted
// butterfly. A LOG_N=13 instance runs one full forward transform and is
// checked on counts and the final tuple.
//
// Tuple encoding used in the tables (every field is below 8 for N=8):
//   ild*100000 + m*10000 + i*1000 + k*100 + addr_top*10 + addr_bot
// -----------------------------------------------------------------------------
module tb_fft_loop_sequencer;

`ifdef FFT_SEQ_STALL_EN
    localparam bit STALL_EN = 1'b1;
`else
    localparam bit STALL_EN = 1'b0;
`endif

    localparam int FWD_TAB [12] = '{
        10001, 10123, 10245, 110367,
        20002, 21013, 20146, 121157,
        40004, 41015, 42026, 143037
    };
    localparam int INV_TAB [12] = '{
        40004, 41015, 42026, 143037,
        20002, 21013, 20146, 121157,
        10001, 10123, 10245, 110367
    };

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;
    int   cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // LOG_N = 3 instance
    logic       start3, dir3, stall3;
    logic       busy3, valid3, ild3, twr3, done3;
    logic [2:0] m3, i3, k3, top3, bot3;

    fft_loop_sequencer #(.LOG_N(3)) dut3 (
        .clk(clk), .rst(rst), .start(start3), .is_forward_fft(dir3), .stall(stall3),
        .busy(busy3), .valid(valid3), .m(m3), .i(i3), .k(k3),
        .addr_top(top3), .addr_bot(bot3), .i_loop_done(ild3), .tw_rst(twr3), .done(done3)
    );

    // Default LOG_N = 13 instance
    logic        start13, dir13, stall13;
    logic        busy13, valid13, ild13, twr13, done13;
    logic [12:0] m13, i13, k13, top13, bot13;

    fft_loop_sequencer dut13 (
        .clk(clk), .rst(rst), .start(start13), .is_forward_fft(dir13), .stall(stall13),
        .busy(busy13), .valid(valid13), .m(m13), .i(i13), .k(k13),
        .addr_top(top13), .addr_bot(bot13), .i_loop_done(ild13), .tw_rst(twr13), .done(done13)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    function automatic int enc(input int mm, input int ii, input int kk,
                               input int tt, input int bb, input int ld);
        return ld * 100000 + mm * 10000 + ii * 1000 + kk * 100 + tt * 10 + bb;
    endfunction

    // ---------------- scoreboard monitor for the LOG_N=3 instance ------------
    int exp_q [$];
    int tw_cnt3 = 0, tw_cyc3 = -1, v_cnt3 = 0, vrise_cyc3 = -1;
    int done_cnt3 = 0, done_cyc3 = -1;
    logic prev_v3 = 1'b0;

    always @(negedge clk) begin
        int code;
        if (!rst) begin
            code = enc(int'(m3), int'(i3), int'(k3), int'(top3), int'(bot3), int'(ild3));
            if (twr3) begin
                tw_cnt3++;
                tw_cyc3 = cyc;
                check("busy_during_tw_rst", int'(busy3), 1);
            end
            if (done3) begin
                done_cnt3++;
                done_cyc3 = cyc;
            end
            if (valid3) begin
                if (!prev_v3) vrise_cyc3 = cyc;
                if (exp_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL sb_unexpected_valid: got tuple %0d expected none", code);
                end else if (STALL_EN && stall3) begin
                    check("held_tuple", code, exp_q[0]);
                end else begin
                    check("tuple", code, exp_q.pop_front());
                    v_cnt3++;
                end
            end
            prev_v3 = valid3;
        end
    end

    // ---------------- counting monitor for the LOG_N=13 instance -------------
    int v13 = 0, ild_cnt13 = 0, done_cnt13 = 0, done_cyc13 = -1;
    int last_v_cyc13 = -1, vrise_cyc13 = -1;
    int lm13 = 0, li13 = 0, lk13 = 0, lt13 = 0, lb13 = 0;
    logic prev_v13 = 1'b0;

    always @(negedge clk) begin
        if (!rst) begin
            if (valid13) begin
                if (!prev_v13) vrise_cyc13 = cyc;
                v13++;
                if (ild13) ild_cnt13++;
                lm13 = int'(m13); li13 = int'(i13); lk13 = int'(k13);
                lt13 = int'(top13); lb13 = int'(bot13);
                last_v_cyc13 = cyc;
            end
            prev_v13 = valid13;
            if (done13) begin
                done_cnt13++;
                done_cyc13 = cyc;
            end
        end
    end

    // ---------------- stimulus ----------------------------------------------
    // One LOG_N=3 transform. Optional 3-cycle stall on butterfly 5
    // (m=2,i=1,k=0) and an optional stray start pulse while running.
    task automatic run3(input bit fwd, input bit do_stall, input bit extra_start,
                        input string tag);
        int t0, tw0, v0, d0, extra;
        for (int n = 0; n < 12; n++) exp_q.push_back(fwd ? FWD_TAB[n] : INV_TAB[n]);
        tw0 = tw_cnt3; v0 = v_cnt3; d0 = done_cnt3;
        extra = (STALL_EN && do_stall) ? 3 : 0;
        @(posedge clk); #1;
        start3 = 1'b1; dir3 = fwd; t0 = cyc;
        @(posedge clk); #1;
        start3 = 1'b0; dir3 = !fwd;     // direction flips after the latch point
        while (done_cnt3 == d0 && cyc < t0 + 60) begin
            @(posedge clk); #1;
            if (do_stall && cyc == t0 + 7) stall3 = 1'b1;
            if (cyc == t0 + 10) stall3 = 1'b0;
            if (extra_start && cyc == t0 + 8) start3 = 1'b1;
            if (cyc == t0 + 9) start3 = 1'b0;
        end
        @(negedge clk);
        check({tag, "_done_count"}, done_cnt3 - d0, 1);
        check({tag, "_busy_after_done"}, int'(busy3), 0);
        check({tag, "_valid_after_done"}, int'(valid3), 0);
        check({tag, "_tw_rst_count"}, tw_cnt3 - tw0, 1);
        check({tag, "_tw_rst_cycle"}, tw_cyc3 - t0, 1);
        check({tag, "_first_valid_cycle"}, vrise_cyc3 - t0, 2);
        check({tag, "_butterflies"}, v_cnt3 - v0, 12);
        check({tag, "_done_cycle"}, done_cyc3 - t0, 14 + extra);
        check({tag, "_queue_left"}, exp_q.size(), 0);
        exp_q.delete();
    endtask

    task automatic reset_mid_run();
        int t0, v0;
        for (int n = 0; n < 12; n++) exp_q.push_back(FWD_TAB[n]);
        v0 = v_cnt3;
        @(posedge clk); #1;
        start3 = 1'b1; dir3 = 1'b1; t0 = cyc;
        @(posedge clk); #1;
        start3 = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        rst = 1'b1;                      // cycle t0+6 carries the 5th butterfly
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("rst_mid_popped", v_cnt3 - v0, 4);
        check("rst_mid_ctrl", int'({busy3, valid3, ild3, done3, twr3}), 0);
        check("rst_mid_tuple", enc(int'(m3), int'(i3), int'(k3), int'(top3), int'(bot3), 0), 0);
        exp_q.delete();
    endtask

    task automatic run13();
        int t0;
        @(posedge clk); #1;
        start13 = 1'b1; dir13 = 1'b1; t0 = cyc;
        @(posedge clk); #1;
        start13 = 1'b0; dir13 = 1'b0;
        while (done_cnt13 == 0 && cyc < t0 + 53300) begin
            @(posedge clk); #1;
        end
        @(negedge clk);
        check("n13_done_count", done_cnt13, 1);
        check("n13_first_valid_cycle", vrise_cyc13 - t0, 2);
        check("n13_valid_cycles", v13, 53248);
        check("n13_i_loop_done_pulses", ild_cnt13, 13);
        check("n13_last_m", lm13, 4096);
        check("n13_last_i", li13, 4095);
        check("n13_last_k", lk13, 0);
        check("n13_last_addr_top", lt13, 4095);
        check("n13_last_addr_bot", lb13, 8191);
        check("n13_done_latency", done_cyc13 - last_v_cyc13, 1);
    endtask

    initial begin
        rst = 1'b1;
        start3 = 1'b0; dir3 = 1'b1; stall3 = 1'b0;
        start13 = 1'b0; dir13 = 1'b1; stall13 = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_ctrl3", int'({busy3, valid3, ild3, done3, twr3}), 0);
        check("reset_tuple3", enc(int'(m3), int'(i3), int'(k3), int'(top3), int'(bot3), 0), 0);
        check("reset_ctrl13", int'({busy13, valid13, ild13, done13, twr13}), 0);
        check("reset_tuple13", int'(m13 | i13 | k13 | top13 | bot13), 0);
        @(posedge clk); #1;
        rst = 1'b0;

        run3(1'b1, 1'b0, 1'b0, "fwd");
        run3(1'b0, 1'b0, 1'b0, "inv");
        run3(1'b1, 1'b1, 1'b0, "stall");
        reset_mid_run();
        run3(1'b1, 1'b0, 1'b0, "after_rst");
        run3(1'b1, 1'b0, 1'b1, "busy_start");
        run13();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
